rect_rasterizer: RTL



---
 rtl/rect_rasterizer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rect_rasterizer.sv
`default_nettype none
// ============================================================================
// Module  : rect_rasterizer
// Brief   : Clears the back buffer, then fills queued rectangles, 1 pixel/clk.
// Revision: 1.0 - initial release
// ============================================================================
module rect_rasterizer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gpu_start,
    input  logic [3:0] bg_color,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [3:0] cmd_color,
    input  logic       cmd_eof,
    output logic [9:0] gpu_x,
    output logic [9:0] gpu_y,
    output logic [3:0] gpu_data,
    output logic       gpu_we,
    output logic       gpu_done
);

    localparam int            c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            c_EW   = 45;
    localparam logic [9:0]    c_XMAX = 10'(WIDTH - 1);
    localparam logic [9:0]    c_YMAX = 10'(HEIGHT - 1);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_FETCH = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    // Command FIFO storage: {x0, y0, x1, y1, color, eof}
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr, r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_ready;

    state_t     r_state, w_state_nxt;
    logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [3:0] r_data, w_data_nxt;
    logic       r_we, w_we_nxt, r_done, w_done_nxt;
    logic [9:0] r_x0, r_x1, r_y1, w_x0_nxt, w_x1_nxt, w_y1_nxt;
    logic       r_eof, w_eof_nxt;

    logic            w_push, w_pop;
    logic [c_AW:0]   w_count_nxt;
    logic [c_EW-1:0] w_head;
    logic [9:0]      w_hx0, w_hy0, w_hx1, w_hy1, w_x1c, w_y1c;
    logic [3:0]      w_hcolor;
    logic            w_heof, w_rect_empty;

    assign w_push      = cmd_valid && r_ready;
    assign w_count_nxt = r_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);

    assign w_head   = r_mem[r_rptr];
    assign w_hx0    = w_head[44:35];
    assign w_hy0    = w_head[34:25];
    assign w_hx1    = w_head[24:15];
    assign w_hy1    = w_head[14:5];
    assign w_hcolor = w_head[4:1];
    assign w_heof   = w_head[0];

    // Clipping the far corner also makes off-screen origins read as empty.
    assign w_x1c        = (w_hx1 > c_XMAX) ? c_XMAX : w_hx1;
    assign w_y1c        = (w_hy1 > c_YMAX) ? c_YMAX : w_hy1;
    assign w_rect_empty = (w_hx0 > w_x1c) || (w_hy0 > w_y1c);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_data_nxt  = r_data;
        w_we_nxt    = r_we;
        w_done_nxt  = r_done;
        w_x0_nxt    = r_x0;
        w_x1_nxt    = r_x1;
        w_y1_nxt    = r_y1;
        w_eof_nxt   = r_eof;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (gpu_start) begin
                    w_state_nxt = S_CLEAR;
                    w_x_nxt     = 10'd0;
                    w_y_nxt     = 10'd0;
                    w_data_nxt  = bg_color;
                    w_we_nxt    = 1'b1;
                    w_done_nxt  = 1'b0;
                end
            end
            S_CLEAR: begin
                if (r_x == c_XMAX) begin
                    w_x_nxt = 10'd0;
                    if (r_y == c_YMAX) begin
                        w_state_nxt = S_FETCH;
                        w_we_nxt    = 1'b0;
                    end else begin
                        w_y_nxt = r_y + 10'd1;
                    end
                end else begin
                    w_x_nxt = r_x + 10'd1;
                end
            end
            S_FETCH: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_rect_empty) begin
                        if (w_heof) begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_DRAW;
                        w_x_nxt     = w_hx0;
                        w_y_nxt     = w_hy0;
                        w_data_nxt  = w_hcolor;
                        w_we_nxt    = 1'b1;
                        w_x0_nxt    = w_hx0;
                        w_x1_nxt    = w_x1c;
                        w_y1_nxt    = w_y1c;
                        w_eof_nxt   = w_heof;
                    end
                end
            end
            S_DRAW: begin
                if (r_x == r_x1) begin
                    if (r_y == r_y1) begin
                        w_we_nxt    = 1'b0;
                        w_done_nxt  = r_eof;
                        w_state_nxt = r_eof ? S_IDLE : S_FETCH;
                    end else begin
                        w_x_nxt = r_x0;
                        w_y_nxt = r_y + 10'd1;
                    end
                end else begin
                    w_x_nxt = r_x + 10'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_data  <= 4'd0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_x0    <= 10'd0;
            r_x1    <= 10'd0;
            r_y1    <= 10'd0;
            r_eof   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_data  <= w_data_nxt;
            r_we    <= w_we_nxt;
            r_done  <= w_done_nxt;
            r_x0    <= w_x0_nxt;
            r_x1    <= w_x1_nxt;
            r_y1    <= w_y1_nxt;
            r_eof   <= w_eof_nxt;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_eof};
        end
    end

    assign cmd_ready = r_ready;
    assign gpu_x     = r_x;
    assign gpu_y     = r_y;
    assign gpu_data  = r_data;
    assign gpu_we    = r_we;
    assign gpu_done  = r_done;

endmodule
`default_nettype wire
